pwm_bank: RTL
=============

Name: pwm_bank

Overview:
- Multi-channel PWM generator. All channels share one programmable period counter.
- Each channel has a double-buffered duty register and optional per-channel slew (soft-start) limiting.
- It is the parametrised successor of the single-channel PWM generator. It drives motor, lift-fan and servo outputs from one block, and a runtime period input replaces the fixed frequency.
- Duty and period changes take effect only at frame boundaries, so no output glitches on update.

Parameters:
CHANNELS, 3, number of independent PWM outputs
DUTY_W, 10, duty resolution in bits (full scale 2^DUTY_W)
CNT_W, 21, period counter width (2,000,000 = 50 Hz at 100 MHz fits)
DEF_PERIOD, 199999, period_reg value after reset (500 Hz at 100 MHz)
RAMP_STEP, 8, maximum duty change per frame on ramp-enabled channels

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
enable  in  1  run counter and outputs; low = idle
period_in  in  CNT_W  requested terminal count (frame = period+1 cycles)
duty_in  in  CHANNELS*DUTY_W  packed requested duties, channel i at [i*DUTY_W +: DUTY_W]
load  in  CHANNELS  per-channel strobe: capture duty_in slice into target
ramp_en  in  CHANNELS  per-channel slew limiting enable
pwm_out  out  CHANNELS  registered PWM outputs
period_tick  out  1  one-cycle pulse on first cycle of each frame
duty_cur  out  CHANNELS*DUTY_W  packed duties currently in effect
busy  out  CHANNELS  channel i: duty_cur != target

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, period_reg=DEF_PERIOD.
  - All targets and duty_cur = 0.
  - pwm_out=0, period_tick=0, busy=0.
  - Outputs clear immediately, with no clock edge needed.
- Effective period:
  - eff = period_in, except that 0 is clamped to 1.
  - period_reg captures eff only at a frame boundary, or every cycle while enable=0.
- Counter:
  - While enable=1, cnt runs 0..period_reg and wraps to 0.
  - The boundary cycle is cnt==period_reg.
  - While enable=0, cnt is held at 0.
- period_tick:
  - Registered. It is 1 in the cycle where cnt==0 following a wrap.
  - It is not asserted on the enable rising edge.
  - It is never asserted while enable=0.
- Target capture:
  - When load[i]=1, target[i] <= duty_in slice i on that edge.
  - Loads on multiple channels in the same cycle are independent.
- Boundary update (edge where cnt==period_reg, enable=1). For each channel, using the target value held before that edge:
  - ramp_en[i]=0: duty_cur[i] <= target[i].
  - ramp_en[i]=1: duty_cur[i] moves toward target[i] by min(RAMP_STEP, |difference|), then stops exactly on target. No overshoot, no wrap.
- Load coincident with a boundary: the boundary uses the old target. The new target applies from the next boundary.
- Enable=0: duty_cur[i] <= target[i] every cycle. Ramp is bypassed.
- Threshold:
  - thr[i] = (period_reg * duty_cur[i]) >> DUTY_W.
  - The product is CNT_W+DUTY_W bits, truncated to CNT_W after the shift.
- Output:
  - pwm_out[i] <= enable & (cnt < thr[i]). One cycle of latency from cnt.
  - duty 0 gives output always low.
  - Full scale (2^DUTY_W-1) gives output low for at least the final cycle of each frame.
- busy[i] is combinational from registers: duty_cur[i] != target[i].
- Enable falling mid-frame: pwm_out goes low on the next edge and cnt returns to 0. No partial-frame tick is issued.

Test Plan:
1. Reset check: assert rst_n=0 between clock edges.
   -> pwm_out=0, period_tick=0, busy=0, duty_cur=0 immediately.
   -> After release with enable=1, the first tick arrives 200000 cycles after cnt starts.
2. Basic duty: period_in=999, ch0 load 256, ramp_en=0, enable=1.
   -> From the frame after the next boundary, pwm0 is high exactly 249 cycles per 1000-cycle frame (thr=249 since period_reg=999).
   -> period_tick spacing is 1000 cycles.
   -> ch1 and ch2 stay low.
3. Shadowing: during a frame running ch0 duty 512, load 128 mid-frame.
   -> The current frame keeps 499 high cycles (period 999).
   -> The next frame has 124 high cycles.
   -> busy0 is high from the load until the boundary.
4. Ramp: RAMP_STEP=8, ramp_en0=1, duty_cur0=0, load 20.
   -> duty_cur0 is 8, 16, 20 after three successive boundaries.
   -> busy0 deasserts after the third.
   -> Repeat downward from 20 to 3: 12, 4, 3.
5. Period change and clamp: change period_in 999 -> 499 mid-frame.
   -> The current frame still completes 1000 cycles, then 500-cycle frames follow.
   -> period_in=0 gives 2-cycle frames and a tick every 2 cycles.
6. Load at boundary plus enable drop:
   -> A load on the cnt==period_reg cycle applies one frame later.
   -> Deasserting enable mid-frame: pwm_out=0 next cycle, cnt=0, no tick, duty_cur jumps to target.

Source files
------------

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: one shared programmable frame counter, per-channel
// double-buffered duties with optional soft-start slew, all updates at frame boundaries.
module pwm_bank #(
    parameter int          CHANNELS   = 3,
    parameter int          DUTY_W     = 10,
    parameter int          CNT_W      = 21,
    parameter int unsigned DEF_PERIOD = 199999,
    parameter int unsigned RAMP_STEP  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [CNT_W-1:0]           period_in,
    input  logic [CHANNELS*DUTY_W-1:0] duty_in,
    input  logic [CHANNELS-1:0]        load,
    input  logic [CHANNELS-1:0]        ramp_en,
    output logic [CHANNELS-1:0]        pwm_out,
    output logic                       period_tick,
    output logic [CHANNELS*DUTY_W-1:0] duty_cur,
    output logic [CHANNELS-1:0]        busy
);

    localparam int PROD_W = CNT_W + DUTY_W;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    period_reg;
    logic [CNT_W-1:0]    eff_period;
    logic                boundary;
    logic [DUTY_W-1:0]   target   [CHANNELS];
    logic [DUTY_W-1:0]   cur      [CHANNELS];
    logic [DUTY_W-1:0]   next_cur [CHANNELS];
    logic [CNT_W-1:0]    thr      [CHANNELS];
    logic [CHANNELS-1:0] pwm_next;

    // A zero terminal count would make a one-cycle frame with no room for a low phase.
    assign eff_period = (period_in == '0) ? CNT_W'(1) : period_in;
    assign boundary   = enable && (cnt == period_reg);

    // Step cur toward tgt by at most RAMP_STEP, landing exactly on tgt.
    function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] from,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] diff;
        if (tgt > from) begin
            diff = tgt - from;
            return (32'(diff) > RAMP_STEP) ? from + DUTY_W'(RAMP_STEP) : tgt;
        end
        diff = from - tgt;
        return (32'(diff) > RAMP_STEP) ? from - DUTY_W'(RAMP_STEP) : tgt;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_reg  <= CNT_W'(DEF_PERIOD);
            period_tick <= 1'b0;
        end else begin
            if (!enable || boundary) begin
                cnt        <= '0;
                period_reg <= eff_period;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Tick lands on the cnt==0 cycle after a wrap; an enable rising edge never wraps.
            period_tick <= boundary;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        logic [PROD_W-1:0] prod;
        prod     = '0;
        pwm_next = '0;
        busy     = '0;
        duty_cur = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            next_cur[i] = cur[i];
            if (!enable) begin
                next_cur[i] = target[i];
            end else if (boundary) begin
                next_cur[i] = ramp_en[i] ? ramp_toward(cur[i], target[i]) : target[i];
            end

            prod   = PROD_W'(period_reg) * PROD_W'(cur[i]);
            thr[i] = CNT_W'(prod >> DUTY_W);

            pwm_next[i]                   = enable && (cnt < thr[i]);
            busy[i]                       = (cur[i] != target[i]);
            duty_cur[i*DUTY_W +: DUTY_W]  = cur[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                cur[i]    <= '0;
            end
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    target[i] <= duty_in[i*DUTY_W +: DUTY_W];
                end
                cur[i] <= next_cur[i];
            end
            pwm_out <= pwm_next;
        end
    end

endmodule
